// File: rtl/inst_fetch_pkg.sv
// Shared types and sizing for the instruction loader / fetch stage.
package inst_fetch_pkg;

  localparam int cXLEN  = 32;
  localparam int cDepth = 256;
  localparam int cAddrW = $clog2(cDepth);

  localparam logic [cAddrW:0]  cFullCnt = (cAddrW+1)'(cDepth);
  localparam logic [cAddrW:0]  cCntOne  = (cAddrW+1)'(1'b1);
  localparam logic [cXLEN-1:0] cPcStep  = cXLEN'(3'd4);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } tFetchState;

  typedef struct packed {
    logic [cXLEN-1:0] inst;
    logic [cXLEN-1:0] curPc;
    logic             dv;
  } tFetchOut;

  // Word index of a byte PC, kept at full width so range checks see wrapped addresses.
  function automatic logic [cXLEN-1:0] word_idx(input logic [cXLEN-1:0] pc);
    return {2'b00, pc[cXLEN-1:2]};
  endfunction

endpackage

// File: rtl/inst_fetch_ram.sv
// Word-addressed instruction RAM: one write port, one synchronous read port.
module inst_ram #(
  parameter int cDepth = 256,
  parameter int cXLEN  = 32,
  parameter int cAddrW = $clog2(cDepth)
) (
  input  logic              iClk,
  input  logic              iWe,
  input  logic [cAddrW-1:0] iWAddr,
  input  logic [cXLEN-1:0]  iWData,
  input  logic              iRe,
  input  logic [cAddrW-1:0] iRAddr,
  output logic [cXLEN-1:0]  oRData
);

  logic [cXLEN-1:0] mem_q [cDepth];

  // No reset and no read-enable-less read so tools map this onto block RAM.
  always_ff @(posedge iClk) begin
    if (iWe) begin
      mem_q[iWAddr] <= iWData;
    end
    if (iRe) begin
      oRData <= mem_q[iRAddr];
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction loader and fetch stage feeding the decoder.
// Optional INST_FETCH_PERF_EN adds fetch / bubble counters.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic [cXLEN-1:0]  iInst2Write,
  input  logic              iInstWen,
  input  logic              iStall,
  input  logic              iBranchTaken,
  input  logic [cXLEN-1:0]  iBranchPc,
  output logic [cXLEN-1:0]  oInst,
  output logic [cXLEN-1:0]  oCurPc,
  output logic              oInstDv,
  output logic [cAddrW:0]   oWrCount,
  output logic              oLoadErr,
  output logic              oHalt,
  output logic              oFault
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0]       oFetchCnt,
  output logic [31:0]       oBubbleCnt
`endif
);

  tFetchState        state_q, state_d;
  logic [cAddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [cXLEN-1:0]  pc_q, pc_d;
  logic              rd_vld_q, rd_vld_d;
  logic [cXLEN-1:0]  rd_pc_q, rd_pc_d;
  tFetchOut          out_q, out_d;
  logic              load_err_q, load_err_d;
  logic              halt_q, halt_d;
  logic              fault_q, fault_d;

  logic              ram_we_s;
  logic              ram_re_s;
  logic [cXLEN-1:0]  ram_rdata_s;
  logic [cXLEN-1:0]  wr_ptr_ext_s;
  logic [cXLEN-1:0]  pc_idx_s;
  logic [cXLEN-1:0]  br_idx_s;

  assign wr_ptr_ext_s = cXLEN'(wr_ptr_q);
  assign pc_idx_s     = word_idx(pc_q);
  assign br_idx_s     = word_idx(iBranchPc);

  inst_ram #(
    .cDepth (cDepth),
    .cXLEN  (cXLEN),
    .cAddrW (cAddrW)
  ) u_ram (
    .iClk   (iClk),
    .iWe    (ram_we_s),
    .iWAddr (wr_ptr_q[cAddrW-1:0]),
    .iWData (iInst2Write),
    .iRe    (ram_re_s),
    .iRAddr (pc_q[cAddrW+1:2]),
    .oRData (ram_rdata_s)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    pc_d       = pc_q;
    rd_vld_d   = rd_vld_q;
    rd_pc_d    = rd_pc_q;
    out_d      = out_q;
    load_err_d = load_err_q;
    halt_d     = halt_q;
    fault_d    = fault_q;
    ram_we_s   = 1'b0;
    ram_re_s   = 1'b0;
    case (state_q)
      LOAD: begin
        if (iInstWen) begin
          if (wr_ptr_q != cFullCnt) begin
            ram_we_s = 1'b1;
            wr_ptr_d = wr_ptr_q + cCntOne;
          end else begin
            load_err_d = 1'b1;
          end
        end else begin
          ram_we_s = 1'b0;
        end
        // Start decision uses the post-write count so a same-cycle write counts.
        if (iStart) begin
          pc_d     = '0;
          rd_vld_d = 1'b0;
          if (wr_ptr_d != '0) begin
            state_d = RUN;
          end else begin
            state_d = HALT;
            halt_d  = 1'b1;
          end
        end else begin
          state_d = LOAD;
        end
      end
      RUN: begin
        if (iBranchTaken) begin
          rd_vld_d = 1'b0;
          out_d.dv = 1'b0;
          if ((iBranchPc[1:0] != 2'b00) || (br_idx_s >= wr_ptr_ext_s)) begin
            state_d = HALT;
            halt_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            pc_d = iBranchPc;
          end
        end else if (iStall) begin
          // Whole pipeline freezes; the RAM output register holds since no read issues.
          ram_re_s = 1'b0;
        end else begin
          if (rd_vld_q) begin
            out_d.inst  = ram_rdata_s;
            out_d.curPc = rd_pc_q;
            out_d.dv    = 1'b1;
          end else begin
            out_d.dv = 1'b0;
          end
          if (pc_idx_s < wr_ptr_ext_s) begin
            ram_re_s = 1'b1;
            rd_vld_d = 1'b1;
            rd_pc_d  = pc_q;
            pc_d     = pc_q + cPcStep;
          end else if (!rd_vld_q) begin
            state_d  = HALT;
            halt_d   = 1'b1;
            rd_vld_d = 1'b0;
            out_d    = out_q;
            out_d.dv = 1'b0;
          end else begin
            rd_vld_d = 1'b0;
          end
        end
      end
      HALT: begin
        out_d.dv = 1'b0;
      end
      default: begin
        state_d  = HALT;
        halt_d   = 1'b1;
        out_d.dv = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q    <= LOAD;
      wr_ptr_q   <= '0;
      pc_q       <= '0;
      rd_vld_q   <= 1'b0;
      rd_pc_q    <= '0;
      out_q      <= '0;
      load_err_q <= 1'b0;
      halt_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      pc_q       <= pc_d;
      rd_vld_q   <= rd_vld_d;
      rd_pc_q    <= rd_pc_d;
      out_q      <= out_d;
      load_err_q <= load_err_d;
      halt_q     <= halt_d;
      fault_q    <= fault_d;
    end
  end

  assign oInst    = out_q.inst;
  assign oCurPc   = out_q.curPc;
  assign oInstDv  = out_q.dv;
  assign oWrCount = wr_ptr_q;
  assign oLoadErr = load_err_q;
  assign oHalt    = halt_q;
  assign oFault   = fault_q;

`ifdef INST_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;
  logic        run_s;
  logic        consume_s;

  assign run_s     = (state_q == RUN);
  assign consume_s = run_s && out_q.dv && !iStall;

  // Saturating counters; they stop at all-ones rather than wrapping.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (consume_s && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (run_s && (!out_q.dv || iStall) && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign oFetchCnt  = fetch_cnt_q;
  assign oBubbleCnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: expected (pc, word) pairs queued at load, popped on consume.
module tb_inst_fetch;

  localparam int DEPTH = 256;

  logic        iClk;
  logic        iRst;
  logic        iStart;
  logic [31:0] iInst2Write;
  logic        iInstWen;
  logic        iStall;
  logic        iBranchTaken;
  logic [31:0] iBranchPc;
  logic [31:0] oInst;
  logic [31:0] oCurPc;
  logic        oInstDv;
  logic [8:0]  oWrCount;
  logic        oLoadErr;
  logic        oHalt;
  logic        oFault;
`ifdef INST_FETCH_PERF_EN
  logic [31:0] oFetchCnt;
  logic [31:0] oBubbleCnt;
`endif

  inst_fetch dut (
    .iClk         (iClk),
    .iRst         (iRst),
    .iStart       (iStart),
    .iInst2Write  (iInst2Write),
    .iInstWen     (iInstWen),
    .iStall       (iStall),
    .iBranchTaken (iBranchTaken),
    .iBranchPc    (iBranchPc),
    .oInst        (oInst),
    .oCurPc       (oCurPc),
    .oInstDv      (oInstDv),
    .oWrCount     (oWrCount),
    .oLoadErr     (oLoadErr),
    .oHalt        (oHalt),
    .oFault       (oFault)
`ifdef INST_FETCH_PERF_EN
    ,
    .oFetchCnt    (oFetchCnt),
    .oBubbleCnt   (oBubbleCnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] prog [DEPTH+2];
  int          n_total = 0;
  int          n_bad   = 0;

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Consumed instructions must match the scoreboard head, in order.
  always @(negedge iClk) begin
    if (iRst && oInstDv && !iStall) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 64'(sb_q.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_pc", oCurPc, e.pc);
        check("sb_inst", oInst, e.inst);
      end
    end
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic do_reset();
    iRst = 1'b0;
    iStart = 1'b0; iInst2Write = 32'd0; iInstWen = 1'b0;
    iStall = 1'b0; iBranchTaken = 1'b0; iBranchPc = 32'd0;
    sb_q.delete();
    tick();
    tick();
    iRst = 1'b1;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) prog[i] = $urandom;
  endtask

  task automatic load_prog(input int n);
    for (int i = 0; i < n; i++) begin
      iInstWen = 1'b1;
      iInst2Write = prog[i];
      tick();
    end
    iInstWen = 1'b0;
  endtask

  task automatic push_idx(input int idx);
    exp_t e;
    e.pc = 32'(idx * 4);
    e.inst = prog[idx];
    sb_q.push_back(e);
  endtask

  task automatic pulse_start();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic wait_pc(input string tag, input logic [31:0] pc);
    int found = 0;
    for (int i = 0; i < 30; i++) begin
      if (oInstDv && oCurPc == pc) begin
        found = 1;
        break;
      end
      tick();
    end
    check(tag, 64'(found), 64'd1);
  endtask

  task automatic run_until_halt(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (oHalt) break;
      tick();
    end
    check(tag, 64'(oHalt), 64'd1);
    check({tag, "_dv"}, 64'(oInstDv), 64'd0);
    check({tag, "_sb_left"}, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inst"}, oInst, 64'd0);
    check({tag, "_pc"}, oCurPc, 64'd0);
    check({tag, "_dv"}, 64'(oInstDv), 64'd0);
    check({tag, "_wrcnt"}, 64'(oWrCount), 64'd0);
    check({tag, "_lerr"}, 64'(oLoadErr), 64'd0);
    check({tag, "_halt"}, 64'(oHalt), 64'd0);
    check({tag, "_fault"}, 64'(oFault), 64'd0);
  endtask

  initial begin
    // Test 1: three-word program, latency and halt.
    do_reset();
    check_reset_outputs("t1_rst");
    prog[0] = 32'h0050_0093; prog[1] = 32'h00A0_0113; prog[2] = 32'h0020_81B3;
    load_prog(3);
    for (int i = 0; i < 3; i++) push_idx(i);
    check("t1_wrcnt_load", 64'(oWrCount), 64'd3);
    pulse_start();
    check("t1_lat0", 64'(oInstDv), 64'd0);
    tick();
    check("t1_lat1", 64'(oInstDv), 64'd0);
    tick();
    check("t1_first_dv", 64'(oInstDv), 64'd1);
    check("t1_first_pc", oCurPc, 64'd0);
    run_until_halt("t1_halt");
    check("t1_wrcnt", 64'(oWrCount), 64'd3);
    check("t1_fault", 64'(oFault), 64'd0);

    // Test 2: 3-cycle stall at PC 0x8.
    do_reset();
    fill_random(10);
    load_prog(10);
    for (int i = 0; i < 10; i++) push_idx(i);
    pulse_start();
    wait_pc("t2_reach8", 32'h8);
    iStall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_frz_pc", oCurPc, 64'h8);
      check("t2_frz_inst", oInst, prog[2]);
      check("t2_frz_dv", 64'(oInstDv), 64'd1);
    end
    iStall = 1'b0;
    tick();
    check("t2_next_pc", oCurPc, 64'hC);
    run_until_halt("t2_halt");
    check("t2_wrcnt", 64'(oWrCount), 64'd10);

    // Test 3: redirect to 0x14 while 0x4 is presented.
    do_reset();
    fill_random(8);
    load_prog(8);
    push_idx(0); push_idx(1); push_idx(5); push_idx(6); push_idx(7);
    pulse_start();
    wait_pc("t3_reach4", 32'h4);
    iBranchTaken = 1'b1;
    iBranchPc = 32'h14;
    tick();
    iBranchTaken = 1'b0;
    check("t3_flush_dv", 64'(oInstDv), 64'd0);
    tick();
    tick();
    check("t3_tgt_dv", 64'(oInstDv), 64'd1);
    check("t3_tgt_pc", oCurPc, 64'h14);
    run_until_halt("t3_halt");
    check("t3_fault", 64'(oFault), 64'd0);

    // Test 4a: misaligned redirect.
    do_reset();
    fill_random(8);
    load_prog(8);
    push_idx(0);
    pulse_start();
    wait_pc("t4a_reach0", 32'h0);
    iBranchTaken = 1'b1;
    iBranchPc = 32'h6;
    tick();
    iBranchTaken = 1'b0;
    check("t4a_fault", 64'(oFault), 64'd1);
    check("t4a_halt", 64'(oHalt), 64'd1);
    check("t4a_dv", 64'(oInstDv), 64'd0);
    tick(); tick(); tick();
    check("t4a_dv_hold", 64'(oInstDv), 64'd0);
    check("t4a_sb_left", 64'(sb_q.size()), 64'd0);

    // Test 4b: out-of-range redirect issued while stalled.
    do_reset();
    fill_random(8);
    load_prog(8);
    pulse_start();
    wait_pc("t4b_reach0", 32'h0);
    iStall = 1'b1;
    iBranchTaken = 1'b1;
    iBranchPc = 32'h40;
    tick();
    iBranchTaken = 1'b0;
    iStall = 1'b0;
    check("t4b_fault", 64'(oFault), 64'd1);
    check("t4b_halt", 64'(oHalt), 64'd1);
    check("t4b_dv", 64'(oInstDv), 64'd0);
    tick(); tick();
    check("t4b_sb_left", 64'(sb_q.size()), 64'd0);

    // Test 5: overfill, then start with an empty RAM.
    do_reset();
    fill_random(DEPTH + 2);
    load_prog(DEPTH);
    check("t5_full_cnt", 64'(oWrCount), 64'(DEPTH));
    check("t5_full_noerr", 64'(oLoadErr), 64'd0);
    iInstWen = 1'b1;
    iInst2Write = prog[DEPTH];
    tick();
    iInst2Write = prog[DEPTH+1];
    tick();
    iInstWen = 1'b0;
    check("t5_over_cnt", 64'(oWrCount), 64'(DEPTH));
    check("t5_over_err", 64'(oLoadErr), 64'd1);
    do_reset();
    check("t5_rst_err", 64'(oLoadErr), 64'd0);
    pulse_start();
    check("t5_empty_halt", 64'(oHalt), 64'd1);
    check("t5_empty_dv", 64'(oInstDv), 64'd0);
    check("t5_empty_fault", 64'(oFault), 64'd0);
    tick(); tick();
    check("t5_empty_dv_hold", 64'(oInstDv), 64'd0);

    // Test 6: asynchronous reset mid-run, then reload and rerun.
    do_reset();
    fill_random(4);
    load_prog(4);
    for (int i = 0; i < 4; i++) push_idx(i);
    pulse_start();
    wait_pc("t6_reach4", 32'h4);
    #3;
    iRst = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    sb_q.delete();
    @(posedge iClk);
    #1;
    iRst = 1'b1;
    fill_random(2);
    load_prog(2);
    push_idx(0); push_idx(1);
    pulse_start();
    run_until_halt("t6_halt");
    check("t6_wrcnt", 64'(oWrCount), 64'd2);
    check("t6_last_pc", oCurPc, 64'h4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
